// File: rtl/time_base_ctrl.sv
// Time-base control block: double-buffered divide registers, restart sequencer
// and accum interrupt/overrun tracking. All outputs come straight from flops.
module time_base_ctrl #(
  parameter logic [23:0] DEF_TIC   = 24'h3D08FF,
  parameter logic [23:0] DEF_ACCUM = 24'h4E1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [23:0] wr_data,
  input  logic        pre_tic_enable,
  input  logic        accum_enable,
  input  logic        accum_ack,
  output logic [23:0] tic_divide,
  output logic [23:0] accum_divide,
  output logic        tb_rstn,
  output logic [1:0]  pending,
  output logic        accum_int,
  output logic        accum_overrun,
  output logic [7:0]  overrun_count
);

  typedef enum logic [1:0] {RUN = 2'd0, RST1 = 2'd1, RST2 = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [23:0] tic_shadow_q, tic_shadow_d;
  logic [23:0] acc_shadow_q, acc_shadow_d;
  logic [23:0] tic_div_q, tic_div_d;
  logic [23:0] acc_div_q, acc_div_d;
  logic [1:0]  pending_q, pending_d;
  logic        int_q, int_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;
  logic        tb_rstn_q, tb_rstn_d;

  logic wr_tic, wr_acc, wr_ctrl;
  logic clr_req, force_req, restart_req, enter_rst1;
  logic commit_tic, commit_acc, ovr_event;

  assign wr_tic      = wr_en && (wr_sel == 2'd0);
  assign wr_acc      = wr_en && (wr_sel == 2'd1);
  assign wr_ctrl     = wr_en && (wr_sel == 2'd2);
  assign clr_req     = wr_ctrl && wr_data[0];
  assign force_req   = wr_ctrl && wr_data[1];
  assign restart_req = wr_ctrl && wr_data[2];
  assign enter_rst1  = (state_q == RUN) && restart_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (restart_req) state_d = RST1;
      RST1:    state_d = RST2;
      RST2:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Commits always move the shadow value held before this edge, so a write
  // landing on a commit edge is kept for the next commit opportunity.
  assign commit_tic = pending_q[0] && (pre_tic_enable || force_req || enter_rst1);
  assign commit_acc = pending_q[1] && (accum_enable || force_req || enter_rst1);
  assign ovr_event  = accum_enable && int_q && !accum_ack;

  always_comb begin
    tic_shadow_d = tic_shadow_q;
    acc_shadow_d = acc_shadow_q;
    tic_div_d    = tic_div_q;
    acc_div_d    = acc_div_q;
    pending_d    = pending_q;
    int_d        = int_q;
    ovr_d        = ovr_q;
    ovr_cnt_d    = ovr_cnt_q;
    tb_rstn_d    = (state_d == RUN);

    if (commit_tic) begin
      tic_div_d    = tic_shadow_q;
      pending_d[0] = 1'b0;
    end
    if (wr_tic) begin
      tic_shadow_d = wr_data;
      pending_d[0] = 1'b1;
    end

    if (commit_acc) begin
      acc_div_d    = acc_shadow_q;
      pending_d[1] = 1'b0;
    end
    if (wr_acc) begin
      acc_shadow_d = wr_data;
      pending_d[1] = 1'b1;
    end

    if (accum_enable)   int_d = 1'b1;
    else if (accum_ack) int_d = 1'b0;

    // An overrun on the same edge as a clear wins and restarts the count at 1.
    if (ovr_event) begin
      ovr_d     = 1'b1;
      ovr_cnt_d = clr_req ? 8'd1 : ((ovr_cnt_q == 8'hFF) ? 8'hFF : ovr_cnt_q + 8'd1);
    end else if (clr_req) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST1;
      tic_shadow_q <= DEF_TIC;
      acc_shadow_q <= DEF_ACCUM;
      tic_div_q    <= DEF_TIC;
      acc_div_q    <= DEF_ACCUM;
      pending_q    <= 2'b00;
      int_q        <= 1'b0;
      ovr_q        <= 1'b0;
      ovr_cnt_q    <= 8'd0;
      tb_rstn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tic_shadow_q <= tic_shadow_d;
      acc_shadow_q <= acc_shadow_d;
      tic_div_q    <= tic_div_d;
      acc_div_q    <= acc_div_d;
      pending_q    <= pending_d;
      int_q        <= int_d;
      ovr_q        <= ovr_d;
      ovr_cnt_q    <= ovr_cnt_d;
      tb_rstn_q    <= tb_rstn_d;
    end
  end

  assign tic_divide    = tic_div_q;
  assign accum_divide  = acc_div_q;
  assign tb_rstn       = tb_rstn_q;
  assign pending       = pending_q;
  assign accum_int     = int_q;
  assign accum_overrun = ovr_q;
  assign overrun_count = ovr_cnt_q;

endmodule
